pe_feeder: RTL

Upstream sequencer for one PE. It reads filter weights and an input activation plane from the global buffer (GLB) and streams them into the PE using the PE's weight-load and activation-load bursts. It then issues one PE start pulse per output row and returns each partial sum on a valid/ready stream to the accumulation stage. One pe_feeder is instantiated per PE inside a cluster.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_feeder_if.sv | 34 +++
 rtl/pe_feeder_glb_burst_reader.sv | 57 +++++
 rtl/pe_feeder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default geometry for the PE feeder.
// Default filter edge 3, activation edge 5, so 9 weights, 25 activations and 3 output rows per job.
package pe_pkg;

    localparam int K       = 3;
    localparam int A       = 5;
    localparam int W_WORDS = K * K;
    localparam int A_WORDS = A * A;
    localparam int N_ROWS  = A - K + 1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        PRE_W  = 4'd1,
        LOAD_W = 4'd2,
        WAIT_W = 4'd3,
        PRE_A  = 4'd4,
        LOAD_A = 4'd5,
        WAIT_A = 4'd6,
        ISSUE  = 4'd7,
        WAIT_C = 4'd8,
        OUT    = 4'd9
    } feeder_state_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of the GLB read port, the PE load/compute port and the psum valid/ready stream.
// The feeder uses the master side; the GLB, the PE and the accumulation stage use the slave side.
interface pe_feeder_if #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GLB_ADDR_BITWIDTH = 12
);
    logic                         gb_rd_en;
    logic [GLB_ADDR_BITWIDTH-1:0] gb_rd_addr;
    logic [DATA_BITWIDTH-1:0]     gb_rd_data;
    logic [DATA_BITWIDTH-1:0]     filt_out;
    logic [DATA_BITWIDTH-1:0]     act_out;
    logic                         load_en_wght;
    logic                         load_en_act;
    logic                         pe_start;
    logic                         pe_load_done;
    logic                         pe_compute_done;
    logic [DATA_BITWIDTH-1:0]     pe_psum;
    logic [DATA_BITWIDTH-1:0]     psum_data;
    logic                         psum_valid;
    logic                         psum_ready;

    modport master (
        output gb_rd_en, gb_rd_addr, filt_out, act_out, load_en_wght, load_en_act,
               pe_start, psum_data, psum_valid,
        input  gb_rd_data, pe_load_done, pe_compute_done, pe_psum, psum_ready
    );

    modport slave (
        input  gb_rd_en, gb_rd_addr, filt_out, act_out, load_en_wght, load_en_act,
               pe_start, psum_data, psum_valid,
        output gb_rd_data, pe_load_done, pe_compute_done, pe_psum, psum_ready
    );

endinterface

// File: rtl/pe_feeder_glb_burst_reader.sv
// Issues a contiguous GLB read burst (base..base+last_idx, first read in the start cycle) and
// returns each word with its index one cycle later; no backpressure, the burst runs uninterrupted.
module glb_burst_reader #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GLB_ADDR_BITWIDTH = 12,
    parameter int CNT_W             = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [GLB_ADDR_BITWIDTH-1:0] base,
    input  logic [CNT_W-1:0]             last_idx,
    output logic                         gb_rd_en,
    output logic [GLB_ADDR_BITWIDTH-1:0] gb_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]     gb_rd_data,
    output logic                         word_vld,
    output logic [DATA_BITWIDTH-1:0]     word,
    output logic [CNT_W-1:0]             word_idx,
    output logic                         word_last
);
    logic                         active;
    logic [GLB_ADDR_BITWIDTH-1:0] addr_q;
    logic [CNT_W-1:0]             idx_q;
    logic [CNT_W-1:0]             last_q;
    logic [CNT_W-1:0]             cur_idx;
    logic [CNT_W-1:0]             cur_last;

    // The start cycle issues word 0 directly so the first word lands on burst cycle 0.
    assign gb_rd_en   = start | active;
    assign gb_rd_addr = start ? base : addr_q;
    assign cur_idx    = start ? '0 : idx_q;
    assign cur_last   = start ? last_idx : last_q;
    assign word       = gb_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            addr_q    <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            word_vld  <= 1'b0;
            word_idx  <= '0;
            word_last <= 1'b0;
        end else begin
            word_vld  <= gb_rd_en;
            word_idx  <= cur_idx;
            word_last <= gb_rd_en && (cur_idx == cur_last);
            if (gb_rd_en) begin
                addr_q <= gb_rd_addr + GLB_ADDR_BITWIDTH'(1);
                idx_q  <= cur_idx + CNT_W'(1);
                last_q <= cur_last;
                active <= (cur_idx != cur_last);
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Sequences one PE job: weight burst, activation burst, then one start/psum per output row.
// Burst words reach the PE with no gaps; a new pe_start waits until the held psum is accepted.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GLB_ADDR_BITWIDTH = 12,
    parameter int kernel_size       = K,
    parameter int act_size          = A
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_start,
    input  logic [GLB_ADDR_BITWIDTH-1:0] w_base,
    input  logic [GLB_ADDR_BITWIDTH-1:0] a_base,
    output logic                         busy,
    output logic                         job_done,
    pe_feeder_if.master                  bus
);
    localparam int W_N   = kernel_size * kernel_size;
    localparam int A_N   = act_size * act_size;
    localparam int ROWS  = act_size - kernel_size + 1;
    localparam int CNT_W = $clog2(A_N);
    localparam int ROW_W = $clog2(ROWS + 1);

    feeder_state_t                state;
    logic [GLB_ADDR_BITWIDTH-1:0] w_base_q;
    logic [GLB_ADDR_BITWIDTH-1:0] a_base_q;
    logic [ROW_W-1:0]             row_cnt;
    logic [DATA_BITWIDTH-1:0]     filt_q;
    logic [DATA_BITWIDTH-1:0]     act_q;
    logic [DATA_BITWIDTH-1:0]     psum_q;

    logic                         rd_start;
    logic [GLB_ADDR_BITWIDTH-1:0] rd_base;
    logic [CNT_W-1:0]             rd_last;
    logic                         word_vld;
    logic [DATA_BITWIDTH-1:0]     word;
    logic [CNT_W-1:0]             word_idx;
    logic                         word_last;
    logic                         w_word;
    logic                         a_word;

    assign rd_start = (state == PRE_W) || (state == PRE_A);
    assign rd_base  = (state == PRE_A) ? a_base_q : w_base_q;
    assign rd_last  = (state == PRE_A) ? CNT_W'(A_N - 1) : CNT_W'(W_N - 1);

    glb_burst_reader #(
        .DATA_BITWIDTH     (DATA_BITWIDTH),
        .GLB_ADDR_BITWIDTH (GLB_ADDR_BITWIDTH),
        .CNT_W             (CNT_W)
    ) u_reader (
        .clk        (clk),
        .reset      (reset),
        .start      (rd_start),
        .base       (rd_base),
        .last_idx   (rd_last),
        .gb_rd_en   (bus.gb_rd_en),
        .gb_rd_addr (bus.gb_rd_addr),
        .gb_rd_data (bus.gb_rd_data),
        .word_vld   (word_vld),
        .word       (word),
        .word_idx   (word_idx),
        .word_last  (word_last)
    );

    assign w_word = (state == LOAD_W) && word_vld;
    assign a_word = (state == LOAD_A) && word_vld;

    // Burst words bypass the hold registers so word i is on the PE bus in burst cycle i.
    assign bus.filt_out     = w_word ? word : filt_q;
    assign bus.act_out      = a_word ? word : act_q;
    assign bus.load_en_wght = w_word && (word_idx == '0);
    assign bus.load_en_act  = a_word && (word_idx == '0);
    assign bus.pe_start     = (state == ISSUE);
    assign bus.psum_valid   = (state == OUT);
    assign bus.psum_data    = psum_q;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            w_base_q <= '0;
            a_base_q <= '0;
            row_cnt  <= '0;
            filt_q   <= '0;
            act_q    <= '0;
            psum_q   <= '0;
            job_done <= 1'b0;
        end else begin
            job_done <= 1'b0;
            if (w_word) filt_q <= word;
            if (a_word) act_q  <= word;
            case (state)
                IDLE: begin
                    if (job_start) begin
                        w_base_q <= w_base;
                        a_base_q <= a_base;
                        row_cnt  <= '0;
                        state    <= PRE_W;
                    end
                end
                PRE_W:  state <= LOAD_W;
                LOAD_W: if (word_vld && word_last) state <= WAIT_W;
                WAIT_W: if (bus.pe_load_done) state <= PRE_A;
                PRE_A:  state <= LOAD_A;
                LOAD_A: if (word_vld && word_last) state <= WAIT_A;
                WAIT_A: if (bus.pe_load_done) state <= ISSUE;
                ISSUE:  state <= WAIT_C;
                WAIT_C: begin
                    if (bus.pe_compute_done) begin
                        psum_q <= bus.pe_psum;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    if (bus.psum_ready) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (row_cnt == ROW_W'(ROWS - 1)) begin
                            job_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
